mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1, rising-edge clock); reset (input, 1, asynchronous active-high reset).
REQ-002 The block SHALL have these EX/MEM-side inputs: RegWriteM, MemtoRegM, MemWriteM, StopM (input, 1 each); ALUOutM (input, 32, address or ALU result); bM (input, 32, store data); rwM (input, 5, destination register).
REQ-003 The block SHALL have these memory-side ports: mem_req (output, 1); mem_we (output, 1); mem_addr (output, 32); mem_wdata (output, 32); mem_rdata (input, 32); mem_ack (input, 1).
REQ-004 The block SHALL have these pipeline-side outputs:
- StallM (1): freeze EX/MEM and all upstream stages.
- RegWriteW, MemtoRegW, StopW (1 each).
- ReadDataW, ALUOutW (32 each).
- rwW (5).
- AlignErrW, TimeoutW (1 each): per-instruction error flags.

Function
REQ-005 An instruction SHALL need access when MemtoRegM|MemWriteM is 1 and ALUOutM[1:0]==0.
REQ-006 An instruction SHALL be misaligned when MemtoRegM|MemWriteM is 1 and ALUOutM[1:0]!=0.
REQ-007 The FSM SHALL have three states: IDLE, REQ and ERRWAIT (reserved, unreachable, decodes as IDLE); reset state is IDLE.
REQ-008 From IDLE with access needed, the FSM SHALL go to REQ at the next edge with StallM=1 in that cycle.
REQ-009 From IDLE with no access needed, the FSM SHALL stay in IDLE.
REQ-010 In REQ, mem_req, mem_addr, mem_we and mem_wdata SHALL be driven as follows:
- mem_req=1.
- mem_addr={ALUOutM[31:2],2'b00}.
- mem_we=MemWriteM.
- mem_wdata=bM.
- All four held stable until ack or timeout.
REQ-011 Outside REQ, mem_req, mem_we, mem_addr and mem_wdata SHALL all be 0.
REQ-012 In REQ with mem_ack=1, StallM SHALL be 0 and the FSM SHALL return to IDLE at that edge.
REQ-013 In REQ with mem_ack=1, ReadDataW SHALL capture mem_rdata at that edge.
REQ-014 mem_ack SHALL be ignored outside REQ.
REQ-015 In REQ with mem_ack=0, StallM SHALL be 1 and a 4-bit wait counter SHALL increment each cycle.
REQ-016 When the wait counter reaches TIMEOUT_LIMIT (15) with no ack, StallM SHALL be 0 and the FSM SHALL return to IDLE.
REQ-017 On timeout, the instruction SHALL be retired with TimeoutW=1 and RegWriteW=0.
REQ-018 The wait counter SHALL clear on entry to REQ and on leaving REQ.
REQ-019 A misaligned instruction SHALL not stall and SHALL not issue mem_req.
REQ-020 A misaligned instruction SHALL retire at the next edge with AlignErrW=1 and RegWriteW=0.
REQ-021 The MEM/WB register SHALL load every edge where StallM=0, carrying RegWriteW (subject to REQ-017/020), MemtoRegW, ALUOutW, rwW and StopW from the M inputs.
REQ-022 AlignErrW and TimeoutW SHALL be 1 for exactly one retired instruction each.
REQ-023 On edges where StallM=1, the MEM/WB register SHALL load a bubble: RegWriteW=0, MemtoRegW=0, StopW=0, both error flags 0.
REQ-024 Latency SHALL be a minimum of 2 cycles per access (IDLE cycle + ack cycle), and 1 cycle for non-memory instructions.
REQ-025 StallM SHALL be combinational from state, the M inputs and mem_ack; every other output SHALL be registered or decoded from state.

Reset
REQ-026 Asserting reset SHALL immediately force state IDLE, counter 0, mem_req=0, and all W outputs 0, including mid-transaction in REQ.
REQ-027 After reset deasserts, the first edge SHALL evaluate the M inputs from IDLE; an ack arriving late for an aborted access SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, REQ, ERRWAIT), TIMEOUT_LIMIT=15, and the width constants (32-bit data, 5-bit register index).
REQ-029 The MEM/WB pipeline register SHALL be a separate sub-module named reg_mem_wb, with load and bubble inputs.
REQ-030 The FSM, wait counter and memory drive SHALL live in mem_access_unit.

Verification
REQ-031 Load with ALUOutM=0x100, ack on 2nd REQ cycle, mem_rdata=0xDEADBEEF -> mem_req high 2 cycles, StallM high 2 cycles, then ReadDataW=0xDEADBEEF, RegWriteW=1.
REQ-032 Store with ALUOutM=0x204, bM=0x12345678, immediate ack -> mem_we=1, mem_addr=0x204, mem_wdata=0x12345678; MEM/WB shows RegWriteW=0 bubble then the store retired.
REQ-033 Load with ALUOutM=0x102 -> no mem_req, no stall, AlignErrW=1, RegWriteW=0 on next edge.
REQ-034 Load with mem_ack held 0 -> StallM released after 15 REQ cycles, TimeoutW=1, RegWriteW=0, mem_req=0.
REQ-035 Reset asserted on 3rd REQ cycle, ack then pulsed -> mem_req=0 immediately, all W outputs 0, ack ignored, state IDLE.
REQ-036 Back-to-back ALU, load, ALU with StopM=1 on last -> correct per-instruction W outputs, StopW=1 on last retirement.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
// Imported by the FSM top and the MEM/WB register.
package mem_access_unit_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        ERRWAIT = 2'b10
    } state_t;

endpackage

// File: rtl/reg_mem_wb.sv
// MEM/WB pipeline register.
// Loads a full instruction, or a control-only bubble while stalled.
module reg_mem_wb
    import mem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic              i_regwrite,
    input  logic              i_memtoreg,
    input  logic              i_stop,
    input  logic              i_alignerr,
    input  logic              i_timeout,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_aluout,
    input  logic [REG_W-1:0]  i_rw,
    output logic              o_regwrite,
    output logic              o_memtoreg,
    output logic              o_stop,
    output logic              o_alignerr,
    output logic              o_timeout,
    output logic [DATA_W-1:0] o_rdata,
    output logic [DATA_W-1:0] o_aluout,
    output logic [REG_W-1:0]  o_rw
);

    // Retire on load; on bubble clear controls but keep data fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_regwrite <= 1'b0;
            o_memtoreg <= 1'b0;
            o_stop     <= 1'b0;
            o_alignerr <= 1'b0;
            o_timeout  <= 1'b0;
            o_rdata    <= '0;
            o_aluout   <= '0;
            o_rw       <= '0;
        end else if (i_load) begin
            o_regwrite <= i_regwrite;
            o_memtoreg <= i_memtoreg;
            o_stop     <= i_stop;
            o_alignerr <= i_alignerr;
            o_timeout  <= i_timeout;
            o_rdata    <= i_rdata;
            o_aluout   <= i_aluout;
            o_rw       <= i_rw;
        end else if (i_bubble) begin
            o_regwrite <= 1'b0;
            o_memtoreg <= 1'b0;
            o_stop     <= 1'b0;
            o_alignerr <= 1'b0;
            o_timeout  <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage access unit: request FSM, wait timeout and memory drive.
// Stalls the pipeline while a word access is outstanding.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic              StopM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] bM,
    input  logic [REG_W-1:0]  rwM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              StopW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [REG_W-1:0]  rwW,
    output logic              AlignErrW,
    output logic              TimeoutW
);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_wait;
    logic [3:0]        w_wait_next;
    logic              r_we;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_mem;
    logic              w_mis;
    logic              w_ack;
    logic              w_to;
    logic              w_stall;
    logic              w_start;

    assign w_mem = MemtoRegM | MemWriteM;

    // Next state, stall and retire qualifiers; ERRWAIT behaves as IDLE.
    always_comb begin
        w_next      = r_state;
        w_wait_next = 4'd0;
        w_stall     = 1'b0;
        w_ack       = 1'b0;
        w_to        = 1'b0;
        w_mis       = 1'b0;
        case (r_state)
            REQ: begin
                if (mem_ack) begin
                    w_next = IDLE;
                    w_ack  = 1'b1;
                end else if (r_wait == TIMEOUT_LIMIT - 4'd1) begin
                    w_next = IDLE;
                    w_to   = 1'b1;
                end else begin
                    w_stall     = 1'b1;
                    w_wait_next = r_wait + 4'd1;
                end
            end
            default: begin
                w_mis = w_mem & (ALUOutM[1:0] != 2'b00);
                if (w_mem && !w_mis) begin
                    w_next  = REQ;
                    w_stall = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
        endcase
    end

    assign w_start = (r_state != REQ) && (w_next == REQ);

    // State, wait counter and latched request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_start) begin
                r_we    <= MemWriteM;
                r_addr  <= {ALUOutM[DATA_W-1:2], 2'b00};
                r_wdata <= bM;
            end
        end
    end

    assign StallM    = w_stall;
    assign mem_req   = (r_state == REQ);
    assign mem_we    = mem_req & r_we;
    assign mem_addr  = mem_req ? r_addr : '0;
    assign mem_wdata = mem_req ? r_wdata : '0;

    reg_mem_wb u_mem_wb (
        .clk        (clk),
        .rst        (reset),
        .i_load     (~w_stall),
        .i_bubble   (w_stall),
        .i_regwrite (RegWriteM & ~w_mis & ~w_to),
        .i_memtoreg (MemtoRegM),
        .i_stop     (StopM),
        .i_alignerr (w_mis),
        .i_timeout  (w_to),
        .i_rdata    (w_ack ? mem_rdata : '0),
        .i_aluout   (ALUOutM),
        .i_rw       (rwM),
        .o_regwrite (RegWriteW),
        .o_memtoreg (MemtoRegW),
        .o_stop     (StopW),
        .o_alignerr (AlignErrW),
        .o_timeout  (TimeoutW),
        .o_rdata    (ReadDataW),
        .o_aluout   (ALUOutW),
        .o_rw       (rwW)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes predicted retirements,
// monitor pops and compares them as the unit retires instructions.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemtoRegM, MemWriteM, StopM;
    logic [31:0] ALUOutM, bM;
    logic [4:0]  rwM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        StallM, RegWriteW, MemtoRegW, StopW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  rwW;
    logic        AlignErrW, TimeoutW;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .StopM(StopM),
        .ALUOutM(ALUOutM), .bM(bM), .rwM(rwM),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .StallM(StallM), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .StopW(StopW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .rwW(rwW),
        .AlignErrW(AlignErrW), .TimeoutW(TimeoutW)
    );

    typedef struct {
        logic        rw_en, m2r, mw, stop;
        logic [31:0] alu, b, rdata;
        logic [4:0]  rd;
        int          ack_at;   // REQ cycle (1-based) that gets ack; 0 = never
    } instr_t;

    typedef struct {
        logic [4:0]  ctl;      // {RegWrite, MemtoReg, Stop, AlignErr, Timeout}
        logic [31:0] alu, rdata, addr, wdata;
        logic [4:0]  rd;
        logic        we, chk_rd;
        int          reqs, stalls;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Reference model: what the unit must retire for one instruction.
    function automatic exp_t predict(input instr_t i);
        exp_t e;
        logic mem, mis, regw, aerr, tout;
        mem  = i.m2r | i.mw;
        mis  = mem && (i.alu % 4 != 0);
        regw = i.rw_en;
        aerr = 1'b0;
        tout = 1'b0;
        e.reqs   = 0;
        e.stalls = 0;
        e.chk_rd = 1'b0;
        e.rdata  = 32'h0;
        if (mis) begin
            aerr = 1'b1;
            regw = 1'b0;
        end else if (mem) begin
            if (i.ack_at >= 1 && i.ack_at <= 15) begin
                // one IDLE stall plus every REQ cycle before the ack
                e.reqs   = i.ack_at;
                e.stalls = i.ack_at;
                e.chk_rd = 1'b1;
                e.rdata  = i.rdata;
            end else begin
                e.reqs   = 15;
                e.stalls = 15;
                tout     = 1'b1;
                regw     = 1'b0;
            end
        end
        e.ctl   = {regw, i.m2r, i.stop, aerr, tout};
        e.alu   = i.alu;
        e.rd    = i.rd;
        e.addr  = i.alu - (i.alu % 4);
        e.we    = i.mw;
        e.wdata = i.b;
        return e;
    endfunction

    task automatic set_m(input instr_t i);
        RegWriteM = i.rw_en;
        MemtoRegM = i.m2r;
        MemWriteM = i.mw;
        StopM     = i.stop;
        ALUOutM   = i.alu;
        bM        = i.b;
        rwM       = i.rd;
    endtask

    // Called at a negedge; holds the instruction until it leaves M.
    task automatic issue(input instr_t i);
        int  reqn;
        bit  done;
        reqn = 0;
        done = 0;
        q.push_back(predict(i));
        set_m(i);
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) begin
                reqn++;
                mem_ack   = (reqn == i.ack_at);
                mem_rdata = (reqn == i.ack_at) ? i.rdata : $urandom;
            end else begin
                mem_ack   = $urandom_range(0, 1) == 1;
                mem_rdata = $urandom;
            end
            #1;
            if (!StallM) done = 1;
            @(negedge clk);
        end
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL issue_timeout: stall got 1 expected 0");
        end
    endtask

    function automatic instr_t mk(input logic rw_en, m2r, mw, stop,
                                  input logic [31:0] alu, b,
                                  input logic [4:0] rd, input int ack_at,
                                  input logic [31:0] rdata);
        instr_t i;
        i.rw_en = rw_en; i.m2r = m2r; i.mw = mw; i.stop = stop;
        i.alu = alu; i.b = b; i.rd = rd; i.ack_at = ack_at; i.rdata = rdata;
        return i;
    endfunction

    function automatic instr_t rnd();
        instr_t i;
        int k;
        k = $urandom_range(0, 9);
        i = mk($urandom_range(0, 1) == 1, 1'b0, 1'b0,
               $urandom_range(0, 7) == 0, $urandom, $urandom,
               5'($urandom), 0, $urandom);
        if (k >= 3) begin
            i.m2r = (k % 2 == 0);
            i.mw  = !i.m2r;
            if (k != 9) i.alu[1:0] = 2'b00;
            k = $urandom_range(0, 19);
            i.ack_at = (k == 0) ? 0 : (k == 1) ? 15 : $urandom_range(1, 4);
        end
        return i;
    endfunction

    // Monitor: per-cycle bus checks and retirement comparison.
    int   reqc = 0, stc = 0;
    logic pend_ret = 1'b0, pend_bub = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!mon_en) begin
            pend_ret = 0; pend_bub = 0; reqc = 0; stc = 0;
        end else begin
            if (pend_ret) begin
                e = q.pop_front();
                chk("ctl", 64'({RegWriteW, MemtoRegW, StopW, AlignErrW, TimeoutW}), 64'(e.ctl));
                chk("aluout", 64'(ALUOutW), 64'(e.alu));
                chk("rw", 64'(rwW), 64'(e.rd));
                chk("req_cycles", 64'(reqc), 64'(e.reqs));
                chk("stall_cycles", 64'(stc), 64'(e.stalls));
                if (e.chk_rd) chk("readdata", 64'(ReadDataW), 64'(e.rdata));
                reqc = 0; stc = 0; pend_ret = 0;
            end
            if (pend_bub) begin
                chk("bubble", 64'({RegWriteW, MemtoRegW, StopW, AlignErrW, TimeoutW}), 64'h0);
                pend_bub = 0;
            end
            if (q.size() > 0) begin
                e = q[0];
                if (mem_req) begin
                    reqc++;
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk("mem_we_wdata", 64'({mem_we, mem_wdata}), 64'({e.we, e.wdata}));
                end else begin
                    chk("idle_bus", 64'({mem_we, mem_addr, mem_wdata}), 64'h0);
                end
                if (StallM) begin
                    stc++;
                    pend_bub = 1;
                end else begin
                    pend_ret = 1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    instr_t nop;

    initial begin
        nop = mk(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        reset = 1'b1;
        set_m(nop);
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_w", 64'({RegWriteW, MemtoRegW, StopW, AlignErrW, TimeoutW, rwW}), 64'h0);
        chk("reset_wdata", 64'({ReadDataW, ALUOutW}), 64'h0);
        chk("reset_mem", 64'({mem_req, mem_we, mem_addr}), 64'h0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // ALU, load acked on 2nd REQ cycle, ALU with Stop
        issue(mk(1, 0, 0, 0, 32'h11, 32'h0, 5'd3, 0, 32'h0));
        issue(mk(1, 1, 0, 0, 32'h100, 32'h0, 5'd4, 2, 32'hDEADBEEF));
        issue(mk(1, 0, 0, 1, 32'h22, 32'h0, 5'd5, 0, 32'h0));
        // store with immediate ack
        issue(mk(0, 0, 1, 0, 32'h204, 32'h12345678, 5'd0, 1, 32'h5A5A5A5A));
        // misaligned load
        issue(mk(1, 1, 0, 0, 32'h102, 32'h0, 5'd6, 1, 32'h0));
        // load never acked, then load acked on the last allowed cycle
        issue(mk(1, 1, 0, 0, 32'h300, 32'h0, 5'd7, 0, 32'h0));
        issue(mk(1, 1, 0, 0, 32'h304, 32'h0, 5'd8, 15, 32'hCAFEF00D));
        set_m(nop);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained_directed", 64'(q.size()), 64'h0);

        // reset in the 3rd REQ cycle, ack pulsed during and after reset
        mon_en = 1'b0;
        set_m(mk(1, 1, 0, 0, 32'h400, 32'h0, 5'd9, 0, 32'h0));
        repeat (3) @(negedge clk);
        #1;
        chk("pre_reset_req", 64'(mem_req), 64'h1);
        reset = 1'b1;
        #1;
        chk("rst_mem_req", 64'({mem_req, mem_we, mem_addr}), 64'h0);
        chk("rst_w_ctl", 64'({RegWriteW, MemtoRegW, StopW, AlignErrW, TimeoutW, rwW}), 64'h0);
        chk("rst_w_data", 64'({ReadDataW, ALUOutW}), 64'h0);
        mem_ack = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("rst_hold_data", 64'({ReadDataW, ALUOutW}), 64'h0);
        set_m(nop);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("late_ack_req", 64'({mem_req, StallM}), 64'h0);
        chk("late_ack_rdata", 64'(ReadDataW), 64'h0);
        mem_ack = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        for (int n = 0; n < 150; n++) issue(rnd());
        set_m(nop);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained_random", 64'(q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
